// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage driving the IF/ID boundary.
// Holds the PC, fetches big-endian 32-bit words from a byte-wide local
// instruction memory, and registers instr / instr_pc / instr_valid for decode.
// Sequencing is a three-state FSM (BOOT, RUN, HALT) with flush, stall,
// end-of-program halt and a wrapping fetch counter.
//
// Optional feature macro: IF_REDIRECT_EN
//   defined   -> redirect_valid / redirect_pc steer the PC (branch/jump)
//   undefined -> redirect ports are present but ignored; HALT is left only
//                by flush or rst
//
// IMEM_BYTES must be a multiple of 4 and at least 8.

module if_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                IMEM_BYTES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              imem_wr_en,
  input  logic [ADDR_W-1:0] imem_wr_addr,
  input  logic [7:0]        imem_wr_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int                IDX_W   = $clog2(IMEM_BYTES);
  localparam logic [ADDR_W:0]   MEM_END = (ADDR_W+1)'(IMEM_BYTES);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------
  logic [7:0]       mem [IMEM_BYTES];
  logic             wr_in_range;
  logic [IDX_W-3:0] word_idx;
  logic [31:0]      fetch_word;

  assign wr_in_range = ({1'b0, imem_wr_addr} < MEM_END);

  // Byte write port for program load; active in every state, even during rst.
  // NOTE: the array is deliberately left out of reset -- clearing every byte
  // would turn it into a bank of resettable flops instead of a RAM, and the
  // program must survive a reset pulse anyway.
  always_ff @(posedge clk) begin
    if (imem_wr_en && wr_in_range) begin
      mem[imem_wr_addr[IDX_W-1:0]] <= imem_wr_data;
    end
  end

  // The PC is always word aligned and below IMEM_BYTES when RUN fetches, so
  // the low index bits select the four bytes of the word directly.
  assign word_idx   = pc[IDX_W-1:2];
  assign fetch_word = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

  // ---------------------------------------------------------------------
  // Next-PC helpers
  // ---------------------------------------------------------------------
  logic [ADDR_W:0] pc_plus4;
  logic            last_word;

  assign pc_plus4  = {1'b0, pc} + (ADDR_W+1)'(4);
  assign last_word = (pc_plus4 >= MEM_END);

`ifdef IF_REDIRECT_EN
  logic [ADDR_W-1:0] redir_target;
  logic              redir_in_range;
  logic              unused_redirect_lsbs;

  assign redir_target         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redir_in_range       = ({1'b0, redir_target} < MEM_END);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`else
  logic unused_redirect;

  assign unused_redirect = redirect_valid ^ (^redirect_pc);
`endif

  // ---------------------------------------------------------------------
  // Fetch FSM with registered outputs; priority rst > flush > redirect >
  // stall > normal operation.
  // ---------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment; that is also what
  // makes a same-edge write to the fetched word return the pre-write data,
  // since fetch_word is sampled before the memory update lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (flush) begin
      // instr / instr_pc keep their last value; only the valid flag drops.
      state       <= S_BOOT;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
`ifdef IF_REDIRECT_EN
    end else if (redirect_valid) begin
      // One-cycle bubble; an out-of-range target parks the fetcher in HALT.
      pc          <= redir_target;
      instr_valid <= 1'b0;
      if (redir_in_range) begin
        state  <= S_RUN;
        halted <= 1'b0;
      end else begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
`endif
    end else if (!stall) begin
      case (state)
        S_BOOT: begin
          instr_valid <= 1'b0;
          state       <= S_RUN;
        end
        S_RUN: begin
          instr       <= fetch_word;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          fetch_count <= fetch_count + CNT_W'(1);
          if (last_word) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc_plus4[ADDR_W-1:0];
          end
        end
        S_HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= S_BOOT;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenario tasks plus a
// randomized run, all compared against a cycle-level behavioural model that
// tracks the program bytes and the fetcher's observable state.
// Build with or without IF_REDIRECT_EN; the redirect scenario adapts.

module tb_if_fetch_unit;

  localparam int                ADDR_W     = 8;
  localparam int                IMEM_BYTES = 16;
  localparam int                CNT_W      = 3;
  localparam int                MIDX_W     = $clog2(IMEM_BYTES);
  localparam logic [ADDR_W-1:0] RESET_PC   = 8'h00;
  localparam int                OUT_W      = 32 + ADDR_W + 1 + ADDR_W + 1 + CNT_W;
`ifdef IF_REDIRECT_EN
  localparam bit REDIR_EN = 1'b1;
`else
  localparam bit REDIR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              imem_wr_en = 1'b0;
  logic [ADDR_W-1:0] imem_wr_addr = '0;
  logic [7:0]        imem_wr_data = '0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W(ADDR_W), .IMEM_BYTES(IMEM_BYTES), .RESET_PC(RESET_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .pc(pc), .halted(halted), .fetch_count(fetch_count)
  );

  int checks = 0;
  int passed = 0;

  // ---------------- behavioural model ----------------
  logic [7:0]        m_mem [IMEM_BYTES];
  logic [31:0]       m_instr;
  logic [ADDR_W-1:0] m_instr_pc, m_pc;
  logic              m_valid, m_halted, m_boot;
  logic [CNT_W-1:0]  m_cnt;

  logic [OUT_W-1:0] exp_out, dut_out;
  assign exp_out = {m_instr, m_instr_pc, m_valid, m_pc, m_halted, m_cnt};
  assign dut_out = {instr, instr_pc, instr_valid, pc, halted, fetch_count};

  localparam logic [OUT_W-1:0] RESET_OUT = {32'h0, 8'h00, 1'b0, RESET_PC, 1'b0, 3'd0};

  function automatic logic [31:0] m_word(input logic [ADDR_W-1:0] a);
    logic [MIDX_W-1:0] b;
    b = a[MIDX_W-1:0];
    return {m_mem[b], m_mem[b + 1], m_mem[b + 2], m_mem[b + 3]};
  endfunction

  task automatic model_reset();
    m_instr = '0; m_instr_pc = '0; m_valid = 1'b0; m_pc = RESET_PC;
    m_halted = 1'b0; m_boot = 1'b1; m_cnt = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    int tgt;
    if (rst) begin
      model_reset();
    end else if (flush) begin
      m_pc = RESET_PC; m_valid = 1'b0; m_cnt = '0; m_boot = 1'b1; m_halted = 1'b0;
    end else if (REDIR_EN && redirect_valid) begin
      tgt      = (int'(redirect_pc) / 4) * 4;
      m_pc     = ADDR_W'(tgt);
      m_valid  = 1'b0;
      m_boot   = 1'b0;
      m_halted = (tgt >= IMEM_BYTES);
    end else if (stall) begin
      // everything holds
    end else if (m_boot) begin
      m_valid = 1'b0;
      m_boot  = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else begin
      m_instr    = m_word(m_pc);
      m_instr_pc = m_pc;
      m_valid    = 1'b1;
      m_cnt      = m_cnt + 1'b1;
      if (int'(m_pc) + 4 >= IMEM_BYTES) m_halted = 1'b1;
      else m_pc = m_pc + 8'd4;
    end
    // Memory is written after the fetch read: same-edge writes are not seen.
    if (imem_wr_en && int'(imem_wr_addr) < IMEM_BYTES)
      m_mem[imem_wr_addr[MIDX_W-1:0]] = imem_wr_data;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] prog [8];
    prog = '{8'h00, 8'h03, 8'h88, 8'h23, 8'h00, 8'h02, 8'h94, 8'h86};
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_out !== RESET_OUT) $display("FAIL reset_async: got %h expected %h", dut_out, RESET_OUT);
    else passed++;
    for (int i = 0; i < IMEM_BYTES; i++) begin
      imem_wr_en   = 1'b1;
      imem_wr_addr = ADDR_W'(i);
      imem_wr_data = (i < 8) ? prog[i] : 8'($urandom);
      cycle();
    end
    imem_wr_en = 1'b0;
    checks++;
    if (dut_out !== RESET_OUT) $display("FAIL reset_hold: got %h expected %h", dut_out, RESET_OUT);
    else passed++;
  endtask

  task automatic test_program_load();
    rst = 1'b0;
    cycle();
    checks++;
    if (dut_out !== exp_out || instr_valid !== 1'b0)
      $display("FAIL load_boot_bubble: got %h expected %h", dut_out, exp_out);
    else passed++;
    cycle();
    checks++;
    if ({instr, instr_pc, instr_valid} !== {32'h00038823, 8'h00, 1'b1} || dut_out !== exp_out)
      $display("FAIL load_first_word: got %h expected %h", dut_out, exp_out);
    else passed++;
    cycle();
    checks++;
    if ({instr, instr_pc, fetch_count} !== {32'h00029486, 8'h04, 3'd2} || dut_out !== exp_out)
      $display("FAIL load_second_word: got %h expected %h", dut_out, exp_out);
    else passed++;
  endtask

  task automatic test_run_halt();
    cycle();
    cycle();
    checks++;
    if ({instr_pc, instr_valid, halted, pc, fetch_count} !== {8'h0C, 1'b1, 1'b1, 8'h0C, 3'd4} ||
        dut_out !== exp_out)
      $display("FAIL halt_last_fetch: got %h expected %h", dut_out, exp_out);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({instr_valid, halted, pc, fetch_count} !== {1'b0, 1'b1, 8'h0C, 3'd4} || dut_out !== exp_out)
        $display("FAIL halt_hold_%0d: got %h expected %h", i, dut_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h08; stall = 1'b1;
    cycle();
    flush = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    checks++;
    if ({pc, fetch_count, instr_valid, halted} !== {RESET_PC, 3'd0, 1'b0, 1'b0} || dut_out !== exp_out)
      $display("FAIL flush_wins: got %h expected %h", dut_out, exp_out);
    else passed++;
    cycle();
    checks++;
    if (instr_valid !== 1'b0 || dut_out !== exp_out)
      $display("FAIL flush_bubble2: got %h expected %h", dut_out, exp_out);
    else passed++;
    cycle();
    checks++;
    if ({instr, instr_pc, instr_valid} !== {32'h00038823, RESET_PC, 1'b1} || dut_out !== exp_out)
      $display("FAIL flush_refetch: got %h expected %h", dut_out, exp_out);
    else passed++;
  endtask

  task automatic test_stall();
    logic [OUT_W-1:0] held;
    cycle();  // fetch 4, pc -> 8
    held = exp_out;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_out !== held) $display("FAIL stall_hold_%0d: got %h expected %h", i, dut_out, held);
      else passed++;
    end
    stall = 1'b0;
    cycle();
    checks++;
    if ({instr_pc, instr_valid, fetch_count} !== {8'h08, 1'b1, 3'd3} || dut_out !== exp_out)
      $display("FAIL stall_resume: got %h expected %h", dut_out, exp_out);
    else passed++;
  endtask

  task automatic test_redirect();
    flush = 1'b1; cycle(); flush = 1'b0;
    cycle(); cycle();  // bubble, fetch 0 -> pc = 4
    redirect_valid = 1'b1; redirect_pc = 8'h0D;
    cycle();
    redirect_valid = 1'b0;
`ifdef IF_REDIRECT_EN
    checks++;
    if ({pc, instr_valid} !== {8'h0C, 1'b0} || dut_out !== exp_out)
      $display("FAIL redir_bubble: got %h expected %h", dut_out, exp_out);
    else passed++;
    cycle();
    checks++;
    if ({instr_pc, instr_valid, halted} !== {8'h0C, 1'b1, 1'b1} || dut_out !== exp_out)
      $display("FAIL redir_target: got %h expected %h", dut_out, exp_out);
    else passed++;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pc, halted, instr_valid} !== {8'h40, 1'b1, 1'b0} || dut_out !== exp_out)
        $display("FAIL redir_oob_%0d: got %h expected %h", i, dut_out, exp_out);
      else passed++;
      cycle();
    end
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checks++;
    if ({instr_pc, instr_valid, halted} !== {8'h04, 1'b1, 1'b0} || dut_out !== exp_out)
      $display("FAIL redir_leave_halt: got %h expected %h", dut_out, exp_out);
    else passed++;
`else
    checks++;
    if ({instr_pc, instr_valid, pc} !== {8'h04, 1'b1, 8'h08} || dut_out !== exp_out)
      $display("FAIL redir_ignored: got %h expected %h", dut_out, exp_out);
    else passed++;
`endif
  endtask

  task automatic test_write_same_cycle();
    flush = 1'b1; cycle(); flush = 1'b0;
    imem_wr_en = 1'b1; imem_wr_addr = 8'h11; imem_wr_data = 8'h5A;  // out of range
    cycle();
    imem_wr_addr = 8'h01; imem_wr_data = 8'hA5;                      // hits fetched word
    cycle();
    imem_wr_en = 1'b0;
    checks++;
    if ({instr, instr_pc} !== {32'h00038823, 8'h00} || dut_out !== exp_out)
      $display("FAIL wr_old_word: got %h expected %h", dut_out, exp_out);
    else passed++;
    flush = 1'b1; cycle(); flush = 1'b0;
    cycle(); cycle();
    checks++;
    if ({instr, instr_pc, instr_valid} !== {32'h00A58823, 8'h00, 1'b1} || dut_out !== exp_out)
      $display("FAIL wr_new_word: got %h expected %h", dut_out, exp_out);
    else passed++;
  endtask

  task automatic test_async_reset();
    cycle();  // RUN, valid output present
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_out !== RESET_OUT) $display("FAIL async_rst_clear: got %h expected %h", dut_out, RESET_OUT);
    else passed++;
    #1 rst = 1'b0;
    cycle();
    cycle();
    checks++;
    if ({instr_pc, instr_valid} !== {RESET_PC, 1'b1} || dut_out !== exp_out)
      $display("FAIL async_rst_restart: got %h expected %h", dut_out, exp_out);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom % 4) == 0;
      flush          = ($urandom % 20) == 0;
      redirect_valid = ($urandom % 6) == 0;
      redirect_pc    = ADDR_W'($urandom_range(0, 19));
      imem_wr_en     = ($urandom % 3) == 0;
      imem_wr_addr   = ADDR_W'($urandom_range(0, 31));
      imem_wr_data   = 8'($urandom);
      cycle();
      checks++;
      if (dut_out !== exp_out) $display("FAIL random_%0d: got %h expected %h", i, dut_out, exp_out);
      else passed++;
    end
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; imem_wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program_load();
    test_run_halt();
    test_flush_priority();
    test_stall();
    test_redirect();
    test_write_same_cycle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
